// File: rtl/uart_bus_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_bus_loader
// Purpose  : Receives a framed program image over a UART line and writes it
//            into the RAM window through the CPU bus, holding the CPU in
//            reset while the bus is owned by the loader.
//            Frame: HEADER, LEN (0 = 256), LEN data bytes, CHK (mod-256 sum).
// Ports    : clock        - system clock
//            reset        - asynchronous, active-low reset
//            rx           - UART receive line (idle high, asynchronous)
//            bus_address  - write address (19 bits)
//            bus_write_en - single-cycle write strobe
//            bus_data_out - write data (8 bits)
//            cpu_reset    - active-low CPU reset; 0 = loader owns the bus
//            busy         - frame in progress
//            error        - sticky: last frame failed
// Revision : 1.0 - initial release
// ============================================================================
module uart_bus_loader #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [18:0] BASE_ADDR    = 19'h0FF00,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [18:0] bus_address,
  output logic        bus_write_en,
  output logic [7:0]  bus_data_out,
  output logic        cpu_reset,
  output logic        busy,
  output logic        error
);

  localparam int           CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_FULL   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_HALF   = CW'(CLKS_PER_BIT / 2 - 1);

  // Receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Frame states
  localparam logic [2:0] M_IDLE  = 3'd0;
  localparam logic [2:0] M_LEN   = 3'd1;
  localparam logic [2:0] M_DATA  = 3'd2;
  localparam logic [2:0] M_CHECK = 3'd3;
  localparam logic [2:0] M_DONE  = 3'd4;
  localparam logic [2:0] M_ERROR = 3'd5;

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  logic          r_rx_s1, r_rx_s2, r_rx_d;
  logic [1:0]    r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;

  logic       w_stop_sample;
  logic       w_byte_valid;
  logic       w_frame_err;
  logic [7:0] w_rx_byte;

  // The stop sample is the instant a byte completes; the shift register
  // already holds all eight data bits at that point.
  assign w_stop_sample = (r_rx_state == RX_STOP) && (r_rx_cnt == c_FULL);
  assign w_byte_valid  = w_stop_sample &&  r_rx_s2;
  assign w_frame_err   = w_stop_sample && !r_rx_s2;
  assign w_rx_byte     = r_shift;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: begin
          // Edge (not level) start so a line stuck low after a framing
          // error does not retrigger endlessly.
          if (r_rx_d && !r_rx_s2) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == c_HALF) begin
            r_rx_cnt <= '0;
            if (r_rx_s2) begin
              r_rx_state <= RX_IDLE;     // glitch, not a start bit
            end else begin
              r_rx_state <= RX_DATA;
              r_bit_idx  <= 3'd0;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == c_FULL) begin
            r_rx_cnt <= '0;
            r_shift  <= {r_rx_s2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            else                   r_bit_idx  <= r_bit_idx + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin // RX_STOP
          if (r_rx_cnt == c_FULL) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame state machine and bus initiator
  // --------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic [8:0]  r_count;
  logic [7:0]  r_sum;
  logic [18:0] r_addr;
  logic [7:0]  r_data;
  logic        r_we;
  logic        r_cpu_reset;
  logic        r_busy;
  logic        r_error;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= M_IDLE;
      r_count     <= 9'd0;
      r_sum       <= 8'd0;
      r_addr      <= BASE_ADDR;
      r_data      <= 8'd0;
      r_we        <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        M_IDLE: begin
          if (w_byte_valid && (w_rx_byte == HEADER)) begin
            r_state     <= M_LEN;
            r_cpu_reset <= 1'b0;
            r_busy      <= 1'b1;
            r_error     <= 1'b0;
          end
        end
        M_LEN: begin
          if (w_frame_err) begin
            r_state <= M_ERROR;
          end else if (w_byte_valid) begin
            r_count <= (w_rx_byte == 8'd0) ? 9'd256 : {1'b0, w_rx_byte};
            r_addr  <= BASE_ADDR;
            r_sum   <= 8'd0;
            r_state <= M_DATA;
          end
        end
        M_DATA: begin
          if (r_we) begin
            // Cycle after the strobe: advance within the 256-byte window.
            r_addr  <= {r_addr[18:8], r_addr[7:0] + 8'd1};
            r_sum   <= r_sum + r_data;
            r_count <= r_count - 9'd1;
            if (r_count == 9'd1) r_state <= M_CHECK;
          end else if (w_frame_err) begin
            r_state <= M_ERROR;
          end else if (w_byte_valid) begin
            r_data <= w_rx_byte;
            r_we   <= 1'b1;
          end
        end
        M_CHECK: begin
          if (w_frame_err) begin
            r_state <= M_ERROR;
          end else if (w_byte_valid) begin
            r_state <= (w_rx_byte == r_sum) ? M_DONE : M_ERROR;
          end
        end
        M_DONE: begin
          r_cpu_reset <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= M_IDLE;
        end
        M_ERROR: begin
          // CPU stays held until a later frame verifies.
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= M_IDLE;
        end
        default: r_state <= M_IDLE;
      endcase
    end
  end

  assign bus_address  = r_addr;
  assign bus_write_en = r_we;
  assign bus_data_out = r_data;
  assign cpu_reset    = r_cpu_reset;
  assign busy         = r_busy;
  assign error        = r_error;

endmodule
`default_nettype wire
